or_unit_arbiter: RTL and testbench
==================================

// Module: or_unit_arbiter
// PURPOSE
//  Shares one combinational bitwise-OR unit (orGate: a, b -> result) between two requesters.
//  Accepts one operation at a time via valid/ready and grants round-robin.
//  Drives the shared unit from registered operands, captures its output and
//  returns it to the owning requester with a one-cycle done pulse.
// PARAMETERS
//  WIDTH  4  operand/result width in bits; must match the shared orGate instance
// PORTS
//  clk          in   1      system clock, all state updates on rising edge
//  rst_n        in   1      synchronous active-low reset
//  req0_valid   in   1      requester 0 has an operation pending
//  req0_a       in   WIDTH  requester 0 operand a
//  req0_b       in   WIDTH  requester 0 operand b
//  req0_ready   out  1      requester 0 operation accepted this cycle
//  req0_done    out  1      one-cycle pulse: req0_result valid
//  req0_result  out  WIDTH  last result returned to requester 0
//  req1_*       same as req0_*, for requester 1
//  alu_a        out  WIDTH  operand a to the shared orGate
//  alu_b        out  WIDTH  operand b to the shared orGate
//  alu_result   in   WIDTH  result from the shared orGate (combinational)
//  busy         out  1      high in EXEC and DONE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, op_a/op_b=0, owner=0,
//   last_grant=1 (so req0 wins first), reqN_result=0, reqN_done=0.
//  reqN_ready and busy are 0 during reset.
//  FSM states IDLE -> EXEC -> DONE -> IDLE.
//  IDLE: readyN is combinational and is high for exactly one requester, only when valid.
//   Only req0 valid: grant 0. Only req1 valid: grant 1. Both valid: grant !last_grant.
//   On grant (validN&&readyN): op_a<=reqN_a, op_b<=reqN_b, owner<=N, go to EXEC.
//   No valid: stay in IDLE, nothing changes.
//  EXEC: reqN_result[owner]<=alu_result, last_grant<=owner, go to DONE.
//  DONE: reqN_done[owner]=1 for this cycle only, go to IDLE.
//  ready is never high in EXEC or DONE; valid asserted then is held off until the next IDLE.
//  alu_a=op_a, alu_b=op_b at all times (registered, glitch-free to the shared unit).
//  Latency: accept at edge T, result register updated at T+1, done high in cycle T+1..T+2.
//   So done is visible the cycle after EXEC.
//  Throughput: at most one op per 3 cycles; full alternation under contention.
//  Requester rule: reqN_a/b are sampled only on the accept edge and may change after it.
//  valid should stay high until ready; dropping valid before ready cancels with no side effect.
//  reqN_result holds its value until that requester's next completion (other requester's ops
//   never change it).
//  Simultaneous: done for one requester and a new valid from the other in the same cycle
//   are legal; the new op is accepted in the following IDLE cycle.
//  Reset mid-operation (EXEC or DONE): op dropped, no done pulse, all state to reset values;
//   requester must re-issue.
//  Widths: no arithmetic; result is exactly WIDTH bits, no carry or overflow.
// TESTING
//  1 req0 a=4'b1110 b=4'b0100 alone -> ready0 at T, done0 one cycle, result0=4'b1110; result1 stays 0.
//  2 req1 a=4'b1111 b=4'b1010 alone -> ready1, done1 pulse, result1=4'b1111; busy high exactly 2 cycles.
//  3 req0 and req1 valid together right after reset -> req0 served first, then req1; done0 before done1.
//  4 both valid continuously for 12 ops -> grants alternate 0,1,0,1...; one accept every 3 cycles.
//  5 rst_n low during EXEC for req0 -> no done0, result0=0, FSM IDLE; re-issued op completes normally.
//  6 req0 valid dropped before ready (during req1 op) -> never accepted, alu_a/b and result0 unchanged.

Source files
------------

// File: rtl/or_unit_arbiter.sv
// -----------------------------------------------------------------------------
// or_unit_arbiter
//   Shares one external combinational bitwise-OR unit between two requesters.
//   One operation is in flight at a time:
//     IDLE -> grant a requester and capture its operands
//     EXEC -> capture the result of the shared OR unit
//     DONE -> pulse done to the owner for one cycle
//   Contention is resolved round-robin, and requester 0 wins first after reset.
//   The operands to the shared unit come straight from registers, so the unit
//   never sees requester-side glitches.
//
// Ports
//   clk                      system clock; all state updates on the rising edge
//   rst_n                    synchronous active-low reset
//   reqN_valid               requester N has an operation pending (N = 0, 1)
//   reqN_a, reqN_b           requester N operands, sampled on the accept edge
//   reqN_ready               requester N operation accepted this cycle
//   reqN_done                one-cycle pulse: reqN_result has just been updated
//   reqN_result              last result returned to requester N (held)
//   alu_a, alu_b             registered operands to the shared OR unit
//   alu_result               combinational result from the shared OR unit
//   busy                     high while an operation is in EXEC or DONE
// -----------------------------------------------------------------------------
module or_unit_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   output logic             req0_done,
   output logic [WIDTH-1:0] req0_result,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             req1_done,
   output logic [WIDTH-1:0] req1_result,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;

   // Per-requester views, so that the arbitration logic can be indexed.
   logic [1:0]       req_valid;
   logic [WIDTH-1:0] req_a      [2];
   logic [WIDTH-1:0] req_b      [2];
   logic [1:0]       grant;
   logic [1:0]       done;
   logic [WIDTH-1:0] result_q   [2];
   logic [WIDTH-1:0] result_d   [2];

   assign req_valid = {req1_valid, req0_valid};
   assign req_a[0]  = req0_a;
   assign req_a[1]  = req1_a;
   assign req_b[0]  = req0_b;
   assign req_b[1]  = req1_b;

   // Round-robin grant. A requester wins when it is alone, or when both are
   // valid and it was not the last one served. Grants happen only in IDLE and
   // are forced low while reset is asserted.
   always_comb begin
      grant = 2'b00;
      if (rst_n && (state_q == ST_IDLE)) begin
         grant[0] = req_valid[0] && (!req_valid[1] ||  last_grant_q);
         grant[1] = req_valid[1] && (!req_valid[0] || !last_grant_q);
      end
   end

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d      = state_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (grant[0]) begin
               op_a_d  = req_a[0];
               op_b_d  = req_b[0];
               owner_d = 1'b0;
               state_d = ST_EXEC;
            end else if (grant[1]) begin
               op_a_d  = req_a[1];
               op_b_d  = req_b[1];
               owner_d = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // The priority pointer moves only once the operation has really
            // executed, so an aborted operation does not cost its owner a turn.
            last_grant_d = owner_q;
            state_d      = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Result registers, one per requester. Each one is written only when its
   // own operation executes, so the other requester's traffic never disturbs it.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_result
         always_comb begin
            result_d[gi] = result_q[gi];
            if ((state_q == ST_EXEC) && (owner_q == 1'(gi))) begin
               result_d[gi] = alu_result;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               result_q[gi] <= '0;
            end else begin
               result_q[gi] <= result_d[gi];
            end
         end

         // Done is gated by rst_n so that an operation aborted by reset while
         // in DONE never produces a pulse.
         always_comb begin
            done[gi] = rst_n && (state_q == ST_DONE) && (owner_q == 1'(gi));
         end
      end
   endgenerate

   // ------------------------------------------------------------------ outputs
   always_comb begin
      req0_ready  = grant[0];
      req1_ready  = grant[1];
      req0_done   = done[0];
      req1_done   = done[1];
      req0_result = result_q[0];
      req1_result = result_q[1];
      alu_a       = op_a_q;
      alu_b       = op_b_q;
      busy        = rst_n && (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_or_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_or_unit_arbiter
//   Directed testbench for or_unit_arbiter. The testbench models the shared OR
//   unit with a continuous assign. Inputs are driven 1 ns after each rising
//   edge, and outputs are checked 1 ns after that.
// -----------------------------------------------------------------------------
module tb_or_unit_arbiter;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             req0_valid, req1_valid;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             req0_ready, req1_ready;
   logic             req0_done, req1_done;
   logic [WIDTH-1:0] req0_result, req1_result;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic             busy;

   int checks = 0;
   int errors = 0;

   or_unit_arbiter #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_ready  (req0_ready),
      .req0_done   (req0_done),
      .req0_result (req0_result),
      .req1_valid  (req1_valid),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_ready  (req1_ready),
      .req1_done   (req1_done),
      .req1_result (req1_result),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .busy        (busy)
   );

   // Shared combinational OR unit.
   assign alu_result = alu_a | alu_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
      $display("check %-14s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
      $display("check %-14s observed=%b expected=%b", tag, obs, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       g;
      logic [3:0] busy_cnt;
      logic [3:0] exp_a;
      logic [3:0] exp_r;

      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a     = '0;
      req0_b     = '0;
      req1_a     = '0;
      req1_b     = '0;
      tick;
      tick;

      // Reset state.
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_busy",   busy,       1'b0);
      chk4("rst_res0",   req0_result, 4'b0000);
      chk4("rst_res1",   req1_result, 4'b0000);
      chk4("rst_alu_a",  alu_a,       4'b0000);
      rst_n = 1'b1;
      tick;

      // 1: req0 alone.
      req0_valid = 1'b1; req0_a = 4'b1110; req0_b = 4'b0100;
      #1;
      chk1("t1_ready0", req0_ready, 1'b1);
      chk1("t1_ready1", req1_ready, 1'b0);
      tick;                                 // accept edge
      req0_valid = 1'b0;
      chk1("t1_busy_ex", busy, 1'b1);
      chk4("t1_alu_a",   alu_a, 4'b1110);
      chk4("t1_alu_b",   alu_b, 4'b0100);
      chk1("t1_nodone",  req0_done, 1'b0);
      tick;                                 // DONE
      chk1("t1_done0",   req0_done, 1'b1);
      chk1("t1_done1",   req1_done, 1'b0);
      chk4("t1_res0",    req0_result, 4'b1110);
      tick;                                 // IDLE
      chk1("t1_done0_lo", req0_done, 1'b0);
      chk1("t1_busy_lo",  busy, 1'b0);
      chk4("t1_res1",     req1_result, 4'b0000);

      // 2: req1 alone; busy high for exactly two cycles.
      req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b1010;
      #1;
      chk1("t2_ready1", req1_ready, 1'b1);
      chk1("t2_ready0", req0_ready, 1'b0);
      busy_cnt = 4'd0;
      tick;                                 // EXEC
      req1_valid = 1'b0;
      busy_cnt = busy_cnt + 4'(busy);
      tick;                                 // DONE
      busy_cnt = busy_cnt + 4'(busy);
      chk1("t2_done1",   req1_done, 1'b1);
      chk4("t2_res1",    req1_result, 4'b1111);
      chk4("t2_res0",    req0_result, 4'b1110);
      tick;                                 // IDLE
      busy_cnt = busy_cnt + 4'(busy);
      tick;
      busy_cnt = busy_cnt + 4'(busy);
      chk4("t2_busy_cnt", busy_cnt, 4'd2);

      // 3: both valid right after reset -> req0 first.
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_a = 4'b1000; req0_b = 4'b0001;
      req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b0100;
      #1;
      chk1("t3_ready0", req0_ready, 1'b1);
      chk1("t3_ready1", req1_ready, 1'b0);
      tick;                                 // accept req0
      req0_valid = 1'b0;
      chk1("t3_ready1_ex", req1_ready, 1'b0);
      tick;                                 // DONE req0
      chk1("t3_done0",   req0_done, 1'b1);
      chk1("t3_done1_lo", req1_done, 1'b0);
      chk1("t3_ready1_dn", req1_ready, 1'b0);
      chk4("t3_res0",    req0_result, 4'b1001);
      tick;                                 // IDLE, req1 still waiting
      chk1("t3_ready1_id", req1_ready, 1'b1);
      tick;                                 // accept req1
      req1_valid = 1'b0;
      tick;                                 // DONE req1
      chk1("t3_done1",   req1_done, 1'b1);
      chk4("t3_res1",    req1_result, 4'b0110);
      chk4("t3_res0_kp", req0_result, 4'b1001);
      tick;                                 // IDLE

      // 4: continuous contention for 12 ops -> strict alternation, 3 cycles each.
      req0_b = 4'b0001;
      req1_b = 4'b1000;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      g = 1'b0;
      for (int i = 0; i < 12; i++) begin
         req0_a = 4'(i);
         req1_a = 4'(i) ^ 4'b1111;
         exp_a  = g ? req1_a : req0_a;
         exp_r  = g ? (req1_a | 4'b1000) : (req0_a | 4'b0001);
         #1;
         chk1("t4_ready0", req0_ready, !g);
         chk1("t4_ready1", req1_ready, g);
         tick;                              // EXEC
         chk1("t4_noready", req0_ready | req1_ready, 1'b0);
         chk4("t4_alu_a",  alu_a, exp_a);
         tick;                              // DONE
         chk1("t4_done0",  req0_done, !g);
         chk1("t4_done1",  req1_done, g);
         chk4("t4_result", g ? req1_result : req0_result, exp_r);
         tick;                              // IDLE
         g = !g;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // 5: reset during EXEC aborts the op; re-issue completes.
      req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0100;
      #1;
      chk1("t5_ready0", req0_ready, 1'b1);
      tick;                                 // EXEC
      req0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk1("t5_busy_rst", busy, 1'b0);
      chk1("t5_done_rst", req0_done, 1'b0);
      tick;                                 // reset applied
      chk1("t5_done_aft", req0_done, 1'b0);
      chk4("t5_res0",     req0_result, 4'b0000);
      chk4("t5_alu_a",    alu_a, 4'b0000);
      rst_n = 1'b1;
      tick;
      chk1("t5_idle",     busy, 1'b0);
      chk1("t5_done_idl", req0_done, 1'b0);
      req0_valid = 1'b1;
      #1;
      chk1("t5_reready0", req0_ready, 1'b1);
      tick;
      req0_valid = 1'b0;
      tick;                                 // DONE
      chk1("t5_redone0",  req0_done, 1'b1);
      chk4("t5_reres0",   req0_result, 4'b0111);
      tick;

      // 6: req0 valid during req1 op, dropped before IDLE -> never accepted.
      req1_valid = 1'b1; req1_a = 4'b0101; req1_b = 4'b0000;
      #1;
      tick;                                 // accept req1
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_a = 4'b1111; req0_b = 4'b1111;
      #1;
      chk1("t6_ready0_ex", req0_ready, 1'b0);
      tick;                                 // DONE
      chk1("t6_ready0_dn", req0_ready, 1'b0);
      chk1("t6_done1",     req1_done, 1'b1);
      req0_valid = 1'b0;
      tick;                                 // IDLE, nothing pending
      chk1("t6_ready0_id", req0_ready, 1'b0);
      chk1("t6_busy",      busy, 1'b0);
      chk4("t6_alu_a",     alu_a, 4'b0101);
      chk4("t6_alu_b",     alu_b, 4'b0000);
      chk4("t6_res0",      req0_result, 4'b0111);
      tick;
      chk1("t6_busy2",     busy, 1'b0);
      chk4("t6_alu_a2",    alu_a, 4'b0101);
      chk4("t6_res0_2",    req0_result, 4'b0111);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
